// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries an opaque payload plus a 32-bit PC. It has valid/ready on both
// sides, flush-to-bubble and a saturating back-pressure counter.
// SKID=1 adds a second entry so that up_ready can come straight from a flop.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter int                SKID      = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [31:0]       up_pc,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [31:0]       dn_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    // One beat as it travels through the stage.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
    } beat_t;

    // Occupancy of the skid variant: main only, or main plus skid.
    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    localparam beat_t BUBBLE = '{data: RESET_VAL, pc: 32'h0};

    beat_t             up_beat;
    beat_t             main_q;
    beat_t             ld_beat;   // value loaded into main when main_ld
    logic              main_ld;
    logic              main_vld_q;
    logic              vld_d;
    logic              up_fire;
    logic              dn_fire;
    logic [CNT_W-1:0]  stall_q;

    assign up_beat = '{data: up_data, pc: up_pc};
    assign up_fire = up_valid & up_ready;
    assign dn_fire = main_vld_q & dn_ready;

    // The outputs come straight from the main-entry flops, so there is no
    // output mux and no combinational path from the inputs to dn_*.
    assign dn_valid  = main_vld_q;
    assign dn_data   = main_q.data;
    assign dn_pc     = main_q.pc;
    assign stall_cnt = stall_q;

    // Main entry. Flush overrides everything and leaves a bubble with the reset payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= BUBBLE;
            main_vld_q <= 1'b0;
        end else if (flush) begin
            main_q     <= BUBBLE;
            main_vld_q <= 1'b0;
        end else begin
            main_vld_q <= vld_d;
            if (main_ld) main_q <= ld_beat;
        end
    end

    // Back-pressure counter. It saturates at all-ones, and flush cycles are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (main_vld_q && !dn_ready && !flush && !(&stall_q))
            stall_q <= stall_q + CNT_W'(1);
    end

    generate
        if (SKID != 0) begin : g_skid
            state_t state_q, state_d;
            beat_t  skid_q;
            logic   skid_ld;
            logic   rdy_q;

            // up_ready is registered. It is low exactly when both entries are occupied.
            assign up_ready = rdy_q;

            // Occupancy state and the registered ready that tracks it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                end else if (flush) begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    rdy_q   <= (state_d != FULL);
                end
            end

            // The skid entry catches the one beat accepted after dn_ready drops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    skid_q <= '0;
                else if (skid_ld && !flush)
                    skid_q <= up_beat;
            end

            // Next-state logic. Main always holds the oldest beat; skid holds the younger one.
            always_comb begin
                state_d = state_q;
                main_ld = 1'b0;
                skid_ld = 1'b0;
                ld_beat = up_beat;
                case (state_q)
                    EMPTY: begin
                        if (up_fire) begin
                            state_d = HALF;
                            main_ld = 1'b1;
                        end
                    end
                    HALF: begin
                        if (up_fire && dn_fire) begin
                            main_ld = 1'b1;
                        end else if (up_fire) begin
                            state_d = FULL;
                            skid_ld = 1'b1;
                        end else if (dn_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        // up_ready is low here, so the only way out is a delivery.
                        if (dn_fire) begin
                            state_d = HALF;
                            main_ld = 1'b1;
                            ld_beat = skid_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                vld_d = (state_d != EMPTY);
            end
        end else begin : g_noskid
            // Single entry: accept whenever the held beat leaves this cycle or there is none.
            assign up_ready = ~main_vld_q | dn_ready;

            // Load on every accepted beat. Otherwise valid drops once the held beat is taken.
            always_comb begin
                main_ld = up_fire;
                ld_beat = up_beat;
                vld_d   = up_fire | (main_vld_q & ~dn_fire);
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Two instances are used: u_a (SKID=1, 4-bit counter)
// and u_b (SKID=0, 16-bit counter, non-zero reset payload). A queue-style
// reference model holds up to 2 or 1 beats and is compared every negedge.
// Directed scenarios also add literal checks.
module tb_pipe_stage_reg;
    localparam logic [63:0] RV_B = 64'hA5A5_0000_C3C3_0001;
    localparam logic [31:0] BASE = 32'h1c00_0000;
    localparam logic [31:0] PA   = 32'h2000_0000;
    localparam logic [31:0] PB   = 32'h2000_0004;
    localparam logic [31:0] PC   = 32'h2000_0008;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_flush = 0, a_up_valid = 0, a_up_ready, a_dn_valid, a_dn_ready = 0;
    logic [63:0] a_up_data = '0, a_dn_data;
    logic [31:0] a_up_pc = '0, a_dn_pc;
    logic [3:0]  a_stall;
    logic        b_flush = 0, b_up_valid = 0, b_up_ready, b_dn_valid, b_dn_ready = 0;
    logic [63:0] b_up_data = '0, b_dn_data;
    logic [31:0] b_up_pc = '0, b_dn_pc;
    logic [15:0] b_stall;

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .RESET_VAL(64'h0), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .up_valid(a_up_valid), .up_ready(a_up_ready), .up_data(a_up_data), .up_pc(a_up_pc),
        .dn_valid(a_dn_valid), .dn_ready(a_dn_ready), .dn_data(a_dn_data), .dn_pc(a_dn_pc),
        .stall_cnt(a_stall));

    pipe_stage_reg #(.DATA_W(64), .SKID(0), .RESET_VAL(RV_B), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data), .up_pc(b_up_pc),
        .dn_valid(b_dn_valid), .dn_ready(b_dn_ready), .dn_data(b_dn_data), .dn_pc(b_dn_pc),
        .stall_cnt(b_stall));

    int checks = 0;
    int failures = 0;

    // Reference model. Index 0 is u_a (capacity 2) and index 1 is u_b (capacity 1).
    int          mcnt [2];
    logic [63:0] mqd  [2][2];
    logic [31:0] mqp  [2][2];
    logic [63:0] mld  [2];
    logic [31:0] mlp  [2];
    int          mst  [2];

    function automatic logic [63:0] rv(input int i);
        return (i == 0) ? 64'h0 : RV_B;
    endfunction

    function automatic int smax(input int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    function automatic logic m_ready(input int i, input logic dr);
        if (i == 0) return (mcnt[0] < 2);
        return (mcnt[1] == 0) || dr;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mld[i] = rv(i); mlp[i] = '0; mst[i] = 0;
            mqd[i][0] = '0; mqd[i][1] = '0; mqp[i][0] = '0; mqp[i][1] = '0;
        end
    endtask

    task automatic m_step(input int i, input logic uv, input logic [63:0] ud,
                          input logic [31:0] upc, input logic dr, input logic fl);
        logic uf, df;
        uf = uv && m_ready(i, dr);
        df = (mcnt[i] > 0) && dr;
        if (mcnt[i] > 0 && !dr && !fl && mst[i] < smax(i)) mst[i]++;
        if (fl) begin
            mcnt[i] = 0; mld[i] = rv(i); mlp[i] = '0;
        end else begin
            if (df) begin
                mld[i] = mqd[i][0]; mlp[i] = mqp[i][0];
                mqd[i][0] = mqd[i][1]; mqp[i][0] = mqp[i][1];
                mcnt[i]--;
            end
            if (uf) begin
                mqd[i][mcnt[i]] = ud; mqp[i][mcnt[i]] = upc;
                mcnt[i]++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input string p, input logic ur, input logic dv,
                            input logic [63:0] dd, input logic [31:0] dp,
                            input logic [63:0] st, input logic dr);
        chk({p, "up_ready"},  64'(ur), 64'(m_ready(i, dr)));
        chk({p, "dn_valid"},  64'(dv), 64'(mcnt[i] > 0));
        chk({p, "dn_data"},   dd, (mcnt[i] > 0) ? mqd[i][0] : mld[i]);
        chk({p, "dn_pc"},     64'(dp), 64'((mcnt[i] > 0) ? mqp[i][0] : mlp[i]));
        chk({p, "stall_cnt"}, st, 64'(mst[i]));
    endtask

    // Advance the model on the same edge the DUT uses.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else begin
            m_step(0, a_up_valid, a_up_data, a_up_pc, a_dn_ready, a_flush);
            m_step(1, b_up_valid, b_up_data, b_up_pc, b_dn_ready, b_flush);
        end
    end

    // Compare both instances against the model mid-cycle.
    always @(negedge clk) begin
        cmp_inst(0, "a_", a_up_ready, a_dn_valid, a_dn_data, a_dn_pc, 64'(a_stall), a_dn_ready);
        cmp_inst(1, "b_", b_up_ready, b_dn_valid, b_dn_data, b_dn_pc, 64'(b_stall), b_dn_ready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_a_up_ready", 64'(a_up_ready), 64'd1);
        chk("rst_b_up_ready", 64'(b_up_ready), 64'd1);
        chk("rst_a_dn_valid", 64'(a_dn_valid), 64'd0);
        chk("rst_b_dn_data",  b_dn_data, RV_B);
        rst_n = 1'b1;
        tick();

        // Streaming with dn_ready held high: each beat appears one cycle later.
        a_dn_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a_up_valid = 1'b1;
            a_up_pc    = BASE + 32'(4 * k);
            a_up_data  = {$urandom, $urandom};
            tick();
            chk("stream_pc",  64'(a_dn_pc), 64'(BASE + 32'(4 * k)));
            chk("stream_vld", 64'(a_dn_valid), 64'd1);
        end
        a_up_valid = 1'b0;
        tick();
        chk("stream_stall", 64'(a_stall), 64'd0);

        // Back-pressure for three cycles with A, B, C offered in turn.
        a_up_valid = 1'b1; a_up_pc = PA;
        tick();
        chk("bp_first", 64'(a_dn_pc), 64'(PA));
        a_dn_ready = 1'b0; a_up_pc = PB;
        chk("bp_ready_half", 64'(a_up_ready), 64'd1);
        tick();
        chk("bp_hold1", 64'(a_dn_pc), 64'(PA));
        chk("bp_ready_full", 64'(a_up_ready), 64'd0);
        a_up_pc = PC;
        tick();
        chk("bp_hold2", 64'(a_dn_pc), 64'(PA));
        tick();
        chk("bp_hold3", 64'(a_dn_pc), 64'(PA));
        chk("bp_stall3", 64'(a_stall), 64'd3);
        a_dn_ready = 1'b1;
        tick();
        chk("bp_out_b", 64'(a_dn_pc), 64'(PB));
        chk("bp_ready_back", 64'(a_up_ready), 64'd1);
        tick();
        chk("bp_out_c", 64'(a_dn_pc), 64'(PC));
        a_up_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(a_dn_valid), 64'd0);

        // Flush while full, with C offered in the same cycle.
        a_dn_ready = 1'b0; a_up_valid = 1'b1; a_up_pc = PA;
        tick();
        a_up_pc = PB;
        tick();
        chk("fl_full", 64'(a_up_ready), 64'd0);
        a_flush = 1'b1; a_up_pc = PC;
        tick();
        chk("fl_vld",   64'(a_dn_valid), 64'd0);
        chk("fl_pc",    64'(a_dn_pc), 64'd0);
        chk("fl_data",  a_dn_data, 64'd0);
        chk("fl_stall", 64'(a_stall), 64'd4);
        a_flush = 1'b0; a_up_valid = 1'b0;
        tick();
        chk("fl_no_c", 64'(a_dn_valid), 64'd0);
        chk("fl_ready", 64'(a_up_ready), 64'd1);

        // Saturation of the 4-bit counter.
        a_up_valid = 1'b1; a_up_pc = PA;
        tick();
        a_up_valid = 1'b0;
        repeat (20) tick();
        chk("sat_15", 64'(a_stall), 64'd15);
        tick();
        chk("sat_stay", 64'(a_stall), 64'd15);

        // Asynchronous reset between edges while u_a is full.
        a_up_valid = 1'b1; a_up_pc = PB;
        tick();
        chk("ar_full", 64'(a_up_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld",   64'(a_dn_valid), 64'd0);
        chk("ar_ready", 64'(a_up_ready), 64'd1);
        chk("ar_data",  a_dn_data, 64'd0);
        chk("ar_pc",    64'(a_dn_pc), 64'd0);
        chk("ar_stall", 64'(a_stall), 64'd0);
        a_up_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // SKID=0: simultaneous accept and deliver, then back-pressure.
        b_dn_ready = 1'b0; b_up_valid = 1'b1; b_up_pc = PA;
        tick();
        chk("s0_a", 64'(b_dn_pc), 64'(PA));
        b_dn_ready = 1'b1; b_up_pc = PB;
        #1 chk("s0_ready_comb", 64'(b_up_ready), 64'd1);
        tick();
        chk("s0_b", 64'(b_dn_pc), 64'(PB));
        b_dn_ready = 1'b0; b_up_pc = PC;
        #1 chk("s0_ready_low", 64'(b_up_ready), 64'd0);
        tick();
        chk("s0_hold", 64'(b_dn_pc), 64'(PB));
        chk("s0_stall", 64'(b_stall), 64'd1);
        b_dn_ready = 1'b1; b_up_valid = 1'b0;
        tick();
        chk("s0_empty", 64'(b_dn_valid), 64'd0);
        chk("s0_held_pc", 64'(b_dn_pc), 64'(PB));
        b_up_valid = 1'b1; b_up_pc = PC;
        tick();
        b_flush = 1'b1;
        tick();
        chk("s0_fl_data", b_dn_data, RV_B);
        chk("s0_fl_pc", 64'(b_dn_pc), 64'd0);
        b_flush = 1'b0; b_up_valid = 1'b0;
        tick();
        chk("s0_fl_vld", 64'(b_dn_valid), 64'd0);

        // Random traffic on both instances. The model compare covers every cycle.
        for (int n = 0; n < 3000; n++) begin
            a_up_valid = ($urandom_range(9) < 7);
            a_up_data  = {$urandom, $urandom};
            a_up_pc    = $urandom;
            a_dn_ready = ($urandom_range(9) < 6);
            a_flush    = ($urandom_range(31) == 0);
            b_up_valid = ($urandom_range(9) < 7);
            b_up_data  = {$urandom, $urandom};
            b_up_pc    = $urandom;
            b_dn_ready = ($urandom_range(9) < 6);
            b_flush    = ($urandom_range(31) == 0);
            tick();
        end
        a_up_valid = 1'b0; a_flush = 1'b0; b_up_valid = 1'b0; b_flush = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register; successor to the fixed-field MM1→MM2 register.
- Carries an opaque DATA_W payload plus a 32-bit PC.
- Adds valid/ready handshaking on both sides, an optional 2-entry skid buffer that registers the upstream ready, flush-to-bubble, and a saturating back-pressure counter.
- Instantiated between any two pipeline stages (IF/ID through MM2/WB).

Parameters:
- DATA_W, 64: payload width in bits (≥1).
- SKID, 1: 1 = 2-entry skid buffer with registered up_ready; 0 = single-entry register with combinational up_ready.
- RESET_VAL, 0: value of dn_data after reset and after flush (DATA_W bits).
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  kill all held beats; synchronous.
- up_valid  in  1  upstream beat valid.
- up_ready  out  1  block can accept a beat.
- up_data  in  DATA_W  upstream payload.
- up_pc  in  32  upstream PC.
- dn_valid  out  1  downstream beat valid.
- dn_ready  in  1  downstream accepts.
- dn_data  out  DATA_W  held payload.
- dn_pc  out  32  held PC.
- stall_cnt  out  CNT_W  count of back-pressured cycles.

Behaviour:
- Transfers:
  - up_fire = up_valid & up_ready.
  - dn_fire = dn_valid & dn_ready.
- Registering: dn_data, dn_pc and dn_valid come directly from the main-entry flops, with no output mux.
- Reset (rst_n=0, asynchronous) forces:
  - state EMPTY, dn_valid=0, dn_data=RESET_VAL, dn_pc=0, skid entry cleared, stall_cnt=0.
  - up_ready=1 for both SKID values.
- Flush has the highest priority. At the next edge:
  - state → EMPTY, dn_valid=0, dn_data=RESET_VAL, dn_pc=0.
  - A beat presented with up_fire in the flush cycle is dropped.
  - dn_fire in the flush cycle still counts as delivered; downstream owns that beat.
  - stall_cnt is not cleared.
- SKID=0:
  - up_ready = ~dn_valid | dn_ready (combinational).
  - On up_fire: main ← up, dn_valid=1.
  - On dn_fire without up_fire: dn_valid=0; data held.
  - Latency is 1 cycle. Full throughput with dn_ready=1.
- SKID=1 state machine:
  - States: EMPTY (0 beats), HALF (main only), FULL (main + skid).
  - up_ready is a flop: 1 in EMPTY and HALF, 0 in FULL.
  - EMPTY: up_fire → HALF, main ← up.
  - HALF, up_fire & dn_fire: stay HALF, main ← up.
  - HALF, up_fire & ~dn_ready: → FULL, skid ← up, main unchanged.
  - HALF, dn_fire only: → EMPTY.
  - HALF, neither: hold.
  - FULL: up_fire impossible. dn_fire → HALF, main ← skid.
  - Latency is 1 cycle. Sustained 1 beat/cycle with dn_ready=1. Strict FIFO ordering.
  - Exactly one cycle of slack absorbed after dn_ready falls. No beat is ever lost or duplicated.
- Data stability: while dn_valid=1 and ~dn_ready, dn_data and dn_pc are stable.
- stall_cnt:
  - Increments by 1 each cycle that dn_valid & ~dn_ready & ~flush.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Invariants:
  - up_valid=0 with X on up_data must never update the held contents.
  - In SKID=0 mode the skid flops and state machine must not be generated.

Test Plan:
- Reset mid-stream, SKID=1: FULL state, assert rst_n=0 asynchronously between edges → dn_valid=0, up_ready=1, dn_data=0, dn_pc=0 immediately, before the next edge.
- Streaming, SKID=1, dn_ready=1: 8 beats pc=0x1c000000+4k back-to-back → same pcs on dn_pc one cycle later, one per cycle, stall_cnt=0.
- Back-pressure, SKID=1: dn_ready low for 3 cycles while up_valid held with pc A,B,C → up_ready drops the cycle after B is captured, C is held upstream, dn_pc=A for 3 cycles, stall_cnt=3. On release, A,B,C delivered in order with no gap.
- Flush with a full buffer: FULL holding A,B with flush=1 and a simultaneous up_valid carrying C → next cycle dn_valid=0, dn_pc=0, dn_data=RESET_VAL. C is never output and stall_cnt is unchanged.
- Simultaneous events, SKID=0: dn_valid=1 with pc A, dn_ready=1 and up_valid=1 with pc B in the same cycle → up_ready=1 combinationally, next cycle dn_pc=B. Repeat with dn_ready=0 → up_ready=0 and A held.
- Saturation with CNT_W=4: hold dn_valid=1, dn_ready=0 for 20 cycles → stall_cnt reads 15 and stays at 15.
